// File: rtl/ex_muldiv_unit_pkg.sv
// ex_muldiv_unit_pkg
//   Shared types and helpers for the execute-stage multiply/divide unit.
//   muldiv_op_t    : decoded op from the ID/EX register (6 and 7 are no-ops)
//   muldiv_state_t : unit FSM state
//   neg2c          : two's-complement negate on a wide vector. Callers
//                    size-cast the operand in and the result out, so one
//                    helper serves both WIDTH and 2*WIDTH quantities.
package ex_muldiv_unit_pkg;

  // Widest operand the neg2c helper covers (WIDTH must not exceed this).
  localparam int unsigned MD_MAXW = 64;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_NOP6  = 3'd6,
    OP_NOP7  = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } muldiv_state_t;

  function automatic logic [2*MD_MAXW-1:0] neg2c(input logic [2*MD_MAXW-1:0] x);
    return ~x + {{(2*MD_MAXW-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// ex_muldiv_unit_if
//   Op issue / result bundle between the EX stage and the mul/div unit.
//   start_i, op_i, a_i, b_i : op request with forwarded rs/rt operands
//   busy_o                  : unit occupied, hazard unit stalls on it
//   done_o                  : one-cycle pulse in the final cycle
//   hi_o, lo_o              : architectural HI/LO registers
//   master drives requests (EX stage / bench), slave is the unit.
interface ex_muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start_i;
  logic [2:0]       op_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start_i, op_i, a_i, b_i,
    input  busy_o, done_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i,
    output busy_o, done_o, hi_o, lo_o
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit
//   Iterative radix-2 multiply/divide with HI/LO registers. One step per
//   cycle, fixed WIDTH+1 cycle occupancy regardless of operand values.
//   Ports:
//     clk_i    : clock, rising edge
//     reset_i  : asynchronous, active-high reset
//     bus      : ex_muldiv_unit_if.slave (request in, busy/done/HI/LO out)
//   Parameters:
//     WIDTH     : operand and HI/LO width (<= MD_MAXW), also the step count
//     CHK_STALL : enable the "no issue while busy" hazard-unit check
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting; MTHI/MTLO write HI/LO here, mul/div ops latch and go
//   RUN   | one shift-add / restoring-divide step per cycle, WIDTH cycles
//   FIN   | sign fix-up, done_o high; HI/LO written on the exit edge
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter bit          CHK_STALL = 1'b1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  ex_muldiv_unit_if.slave    bus
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned W2 = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  muldiv_state_t    state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;     // negate product / quotient
  logic             rneg_q, rneg_d;   // negate remainder (dividend was negative)
  logic             dz_q, dz_d;       // divisor was zero
  logic [WIDTH-1:0] m_q, m_d;         // multiplicand or divisor magnitude
  logic [WIDTH-1:0] alat_q, alat_d;   // raw a_i, HI result for divide by zero
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  muldiv_op_t op_in;
  logic       op_div, op_signed;
  logic       a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign op_in     = muldiv_op_t'(bus.op_i);
  assign op_div    = (op_in == OP_DIV) || (op_in == OP_DIVU);
  assign op_signed = (op_in == OP_MULT) || (op_in == OP_DIV);
  assign a_neg     = op_signed & bus.a_i[WIDTH-1];
  assign b_neg     = op_signed & bus.b_i[WIDTH-1];
  assign a_mag     = a_neg ? WIDTH'(neg2c((2*MD_MAXW)'(bus.a_i))) : bus.a_i;
  assign b_mag     = b_neg ? WIDTH'(neg2c((2*MD_MAXW)'(bus.b_i))) : bus.b_i;

  // Multiply step: acc = {partial product, remaining multiplier bits}.
  // The W+1 bit sum keeps the carry, which shifts down into the upper half.
  logic [WIDTH:0]  mul_sum;
  logic [W2-1:0]   mul_next;
  assign mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring divide step: acc = {remainder, dividend bits / quotient bits}.
  logic [WIDTH:0]  div_rsh, div_diff;
  logic            div_ok;
  logic [W2-1:0]   div_next;
  assign div_rsh  = acc_q[W2-1:WIDTH-1];
  assign div_diff = div_rsh - {1'b0, m_q};
  assign div_ok   = ~div_diff[WIDTH];
  assign div_next = {(div_ok ? div_diff[WIDTH-1:0] : div_rsh[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], div_ok};

  // Sign fix-up applied in FIN.
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  assign prod_fix = neg_q  ? W2'(neg2c((2*MD_MAXW)'(acc_q))) : acc_q;
  assign quo_fix  = neg_q  ? WIDTH'(neg2c((2*MD_MAXW)'(acc_q[WIDTH-1:0])))
                           : acc_q[WIDTH-1:0];
  assign rem_fix  = rneg_q ? WIDTH'(neg2c((2*MD_MAXW)'(acc_q[W2-1:WIDTH])))
                           : acc_q[W2-1:WIDTH];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      m_q      <= '0;
      alat_q   <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      m_q      <= m_d;
      alat_q   <= alat_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    m_d      = m_q;
    alat_d   = alat_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          case (op_in)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              state_d  = ST_RUN;
              count_d  = '0;
              is_div_d = op_div;
              neg_d    = a_neg ^ b_neg;
              rneg_d   = op_div & a_neg;
              dz_d     = op_div & (bus.b_i == '0);
              alat_d   = bus.a_i;
              if (op_div) begin
                acc_d = {{WIDTH{1'b0}}, a_mag};
                m_d   = b_mag;
              end else begin
                acc_d = {{WIDTH{1'b0}}, b_mag};
                m_d   = a_mag;
              end
            end
            OP_MTHI: hi_d = bus.a_i;
            OP_MTLO: lo_d = bus.a_i;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        acc_d   = is_div_q ? div_next : mul_next;
        count_d = count_q + CW'(1);
        if (count_q == LAST) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        if (is_div_q) begin
          lo_d = dz_q ? '1     : quo_fix;
          hi_d = dz_q ? alat_q : rem_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.busy_o = (state_q != ST_IDLE);
  assign bus.done_o = (state_q == ST_FIN);
  assign bus.hi_o   = hi_q;
  assign bus.lo_o   = lo_q;

  // The hazard unit must hold any real op in EX while the unit is busy.
  a_no_issue_while_busy : assert property (
    @(posedge clk_i) disable iff (reset_i)
      !(CHK_STALL && bus.start_i && bus.busy_o && (bus.op_i <= 3'd5))
  );

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;
  import ex_muldiv_unit_pkg::*;

  logic clk_i = 1'b0;
  logic reset_i;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk_i = ~clk_i;

  ex_muldiv_unit_if #(.WIDTH(32)) bus ();

  // The stall check is off here: one case deliberately issues MTLO while
  // busy to confirm the unit ignores it.
  ex_muldiv_unit #(.WIDTH(32), .CHK_STALL(1'b0)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk_i);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.a_i     = a;
    bus.b_i     = b;
    @(negedge clk_i);
    bus.start_i = 1'b0;
  endtask

  // Issues a mul/div and follows it to completion, counting busy cycles and
  // done pulses. inj_at >= 0 injects an illegal MTLO that many cycles in.
  task automatic run_op(input string tag, input muldiv_op_t op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input int inj_at, input logic [31:0] inj_val);
    int nb = 0;
    int nd = 0;
    logic [31:0] lo_before;
    lo_before = bus.lo_o;
    issue(op, a, b);
    for (int i = 0; i < 100; i++) begin
      if (!bus.busy_o) break;
      nb++;
      if (bus.done_o) nd++;
      if (i == inj_at) begin
        bus.start_i = 1'b1;
        bus.op_i    = OP_MTLO;
        bus.a_i     = inj_val;
      end
      if (inj_at >= 0 && i == inj_at + 1) begin
        bus.start_i = 1'b0;
        chk({tag, "_mtlo_ignored"}, bus.lo_o, lo_before);
      end
      @(negedge clk_i);
    end
    chk({tag, "_busy_cycles"}, nb, 33);
    chk({tag, "_done_pulses"}, nd, 1);
    chk({tag, "_hi"}, bus.hi_o, exp_hi);
    chk({tag, "_lo"}, bus.lo_o, exp_lo);
  endtask

  initial begin
    int nd;
    reset_i     = 1'b1;
    bus.start_i = 1'b0;
    bus.op_i    = OP_NOP7;
    bus.a_i     = '0;
    bus.b_i     = '0;
    #1;
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_done", bus.done_o, 0);
    chk("rst_hi", bus.hi_o, 0);
    chk("rst_lo", bus.lo_o, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;

    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, -1, '0);
    run_op("mult_m3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, -1, '0);
    run_op("mult_minsq", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, -1, '0);
    run_op("mult_m1m1", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, -1, '0);
    run_op("div_m7d2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1, '0);
    run_op("divu_100d7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, -1, '0);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, -1, '0);
    run_op("divu_dz", OP_DIVU, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF, -1, '0);
    run_op("div_dz", OP_DIV, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF, -1, '0);
    run_op("div_dz_neg", OP_DIV, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, -1, '0);

    issue(OP_MTHI, 32'hDEAD_BEEF, 32'h0);
    chk("mthi_hi", bus.hi_o, 32'hDEAD_BEEF);
    chk("mthi_busy", bus.busy_o, 0);
    issue(OP_MTLO, 32'h1111_1111, 32'h0);
    chk("mtlo_lo", bus.lo_o, 32'h1111_1111);
    chk("mtlo_hi_kept", bus.hi_o, 32'hDEAD_BEEF);
    issue(OP_NOP6, 32'h5555_5555, 32'h0);
    chk("nop6_hi", bus.hi_o, 32'hDEAD_BEEF);
    chk("nop6_lo", bus.lo_o, 32'h1111_1111);
    chk("nop6_busy", bus.busy_o, 0);

    run_op("divu_inj", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 5, 32'hCAFE_F00D);

    // Reset mid-MULT, between clock edges.
    issue(OP_MULT, 32'd5, 32'd6);
    repeat (9) @(negedge clk_i);
    chk("pre_rst_busy", bus.busy_o, 1);
    #2;
    reset_i = 1'b1;
    #1;
    chk("midrst_busy", bus.busy_o, 0);
    chk("midrst_hi", bus.hi_o, 0);
    chk("midrst_lo", bus.lo_o, 0);
    nd = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      if (bus.done_o) nd++;
    end
    reset_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (bus.done_o) nd++;
    end
    chk("midrst_no_done", nd, 0);
    chk("midrst_idle_hi", bus.hi_o, 0);
    run_op("divu_after_rst", OP_DIVU, 32'd1000, 32'd33, 32'd10, 32'd30, -1, '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
